// File: rtl/pixel_sync_pipe.sv
// rtl/pixel_sync_pipe.sv - CRTC timing delay line, blink/cursor attribute logic and registered video output
module pixel_sync_pipe #(
  parameter int COLOR_W      = 4,
  parameter int SYNC_DELAY   = 2,
  parameter int BLINK_FRAMES = 16,
  parameter int SYNC_POL     = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 hsync_i,
  input  logic                 vsync_i,
  input  logic                 video_on_i,
  input  logic                 pixel_i,
  input  logic                 cursor_i,
  input  logic                 blink_i,
  input  logic [1:0]           cursor_mode_i,
  input  logic [3*COLOR_W-1:0] fg_rgb_i,
  input  logic [3*COLOR_W-1:0] bg_rgb_i,
  output logic [3*COLOR_W-1:0] rgb_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 blink_phase_o
);

  localparam int       RGB_W    = 3 * COLOR_W;
  localparam logic     SYNC_INV = (SYNC_POL == 0);
  localparam logic [7:0] CNT_LAST = 8'(BLINK_FRAMES - 1);

  logic [2:0] timing_in;
  logic [2:0] timing_dly;  // {hsync, vsync, video_on} after the delay line

  assign timing_in = {hsync_i, vsync_i, video_on_i};

  generate
    if (SYNC_DELAY == 0) begin : g_bypass
      assign timing_dly = timing_in;
    end else begin : g_delay
      logic [2:0] dl_q [SYNC_DELAY];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < SYNC_DELAY; i++) dl_q[i] <= 3'b000;
        end else if (en_i) begin
          dl_q[0] <= timing_in;
          for (int i = 1; i < SYNC_DELAY; i++) dl_q[i] <= dl_q[i-1];
        end
      end

      assign timing_dly = dl_q[SYNC_DELAY-1];
    end
  endgenerate

  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, vsync_q;
  logic             vs_prev_q;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             blink_q, blink_d;
  logic             fg_on, cur_inv, fg_final, vs_rise;

  always_comb begin
    fg_on = pixel_i & ~(blink_i & blink_q);
    case (cursor_mode_i)
      2'b00:   cur_inv = 1'b0;
      2'b10:   cur_inv = cursor_i & ~blink_q;
      default: cur_inv = cursor_i;
    endcase
    fg_final = fg_on ^ cur_inv;
    rgb_d    = timing_dly[0] ? (fg_final ? fg_rgb_i : bg_rgb_i) : '0;

    // Blink period spans BLINK_FRAMES vsync rising edges per half-phase
    vs_rise     = timing_dly[1] & ~vs_prev_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (vs_rise) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = 8'd0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rgb_q       <= '0;
      hsync_q     <= SYNC_INV;
      vsync_q     <= SYNC_INV;
      vs_prev_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
    end else if (en_i) begin
      rgb_q       <= rgb_d;
      hsync_q     <= timing_dly[2] ^ SYNC_INV;
      vsync_q     <= timing_dly[1] ^ SYNC_INV;
      vs_prev_q   <= timing_dly[1];
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign rgb_o         = rgb_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign blink_phase_o = blink_q;

endmodule

// File: tb/tb_pixel_sync_pipe.sv
// tb/tb_pixel_sync_pipe.sv - self-checking bench for pixel_sync_pipe
module tb_pixel_sync_pipe;
  localparam int SD  = 2;
  localparam int BF  = 2;
  localparam int POL = 0;

  logic        clk = 1'b0;
  logic        rst, en, hsync, vsync, video_on, pixel, cursor, blink;
  logic [1:0]  cmode;
  logic [11:0] fg, bg;
  logic [11:0] rgb_w;
  logic        hsync_w, vsync_w, phase_w;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_sync_pipe #(
    .COLOR_W(4), .SYNC_DELAY(SD), .BLINK_FRAMES(BF), .SYNC_POL(POL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .hsync_i(hsync), .vsync_i(vsync), .video_on_i(video_on),
    .pixel_i(pixel), .cursor_i(cursor), .blink_i(blink),
    .cursor_mode_i(cmode), .fg_rgb_i(fg), .bg_rgb_i(bg),
    .rgb_o(rgb_w), .hsync_o(hsync_w), .vsync_o(vsync_w),
    .blink_phase_o(phase_w)
  );

  always #5 clk = ~clk;

  // Reference model: history of timing samples per tick, edge count -> phase
  logic [2:0]  hist[$];
  int          edge_cnt;
  bit          prev_dv;
  logic [11:0] e_rgb;
  logic        e_hs, e_vs, e_ph;

  function automatic void model_reset();
    hist.delete();
    edge_cnt = 0;
    prev_dv  = 1'b0;
    e_rgb    = 12'h000;
    e_hs     = (POL == 0);
    e_vs     = (POL == 0);
    e_ph     = 1'b0;
  endfunction

  function automatic void model_tick();
    logic [2:0] d;
    bit ph, shown, cur_vis;
    int n;
    hist.push_back({hsync, vsync, video_on});
    n = hist.size() - 1;
    d = (n >= SD) ? hist[n-SD] : 3'b000;
    ph = ((edge_cnt / BF) % 2) == 1;
    shown = pixel && !(blink && ph);
    cur_vis = (cmode == 2'b01) || (cmode == 2'b11) || (cmode == 2'b10 && !ph);
    if (cursor && cur_vis) shown = !shown;
    e_rgb = d[0] ? (shown ? fg : bg) : 12'h000;
    if (d[1] && !prev_dv) edge_cnt++;
    prev_dv = d[1];
    if (POL == 1) begin
      e_hs = d[2];
      e_vs = d[1];
    end else begin
      e_hs = !d[2];
      e_vs = !d[1];
    end
    e_ph = ((edge_cnt / BF) % 2) == 1;
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    chk("rgb_o", rgb_w, e_rgb);
    chk("hsync_o", {11'd0, hsync_w}, {11'd0, e_hs});
    chk("vsync_o", {11'd0, vsync_w}, {11'd0, e_vs});
    chk("blink_phase_o", {11'd0, phase_w}, {11'd0, e_ph});
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rgb"}, rgb_w, 12'h000);
    chk({nm, "_hsync"}, {11'd0, hsync_w}, 12'h001);
    chk({nm, "_vsync"}, {11'd0, vsync_w}, 12'h001);
    chk({nm, "_phase"}, {11'd0, phase_w}, 12'h000);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst && en) model_tick();
    #1;
    check_all();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    repeat (3) step();
  endtask

  typedef struct packed {
    logic        pix, cur, blk;
    logic [1:0]  mode;
    logic [11:0] fgc, bgc, exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 12'hAAA, 12'h000, 12'hAAA};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 2'b00, 12'hAAA, 12'h000, 12'h000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 2'b01, 12'hAAA, 12'h000, 12'h000};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 2'b01, 12'hAAA, 12'h000, 12'hAAA};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 2'b11, 12'h5A3, 12'h1C7, 12'h1C7};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 2'b10, 12'h5A3, 12'h1C7, 12'h5A3};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 2'b00, 12'h5A3, 12'h1C7, 12'h5A3};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 2'b01, 12'h5A3, 12'h1C7, 12'h5A3};

    rst = 1'b1; en = 1'b1;
    hsync = 0; vsync = 0; video_on = 0; pixel = 0; cursor = 0; blink = 0;
    cmode = 2'b00; fg = 12'h000; bg = 12'h000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // Sync latency: hsync rises at tick 0, output goes active after tick 2
    repeat (3) step();
    hsync = 1'b1; video_on = 1'b1;
    step(); chk("lat_t0", {11'd0, hsync_w}, 12'h001);
    step(); chk("lat_t1", {11'd0, hsync_w}, 12'h001);
    step(); chk("lat_t2", {11'd0, hsync_w}, 12'h000);
    hsync = 1'b0;

    for (int i = 0; i < 8; i++) begin
      pixel = vecs[i].pix; cursor = vecs[i].cur; blink = vecs[i].blk;
      cmode = vecs[i].mode; fg = vecs[i].fgc; bg = vecs[i].bgc;
      step();
      chk($sformatf("vec%0d_rgb", i), rgb_w, vecs[i].exp);
    end

    pixel = 1; cursor = 0; blink = 0; cmode = 2'b00; fg = 12'hAAA; bg = 12'h000;
    video_on = 1'b0;
    repeat (3) step();
    chk("video_off_rgb", rgb_w, 12'h000);
    video_on = 1'b1;

    // Blink: BLINK_FRAMES=2 -> phase toggles after 2nd and 4th vsync pulse
    pixel = 0;
    vs_pulse(); chk("pulse1_phase", {11'd0, phase_w}, 12'h000);
    vs_pulse(); chk("pulse2_phase", {11'd0, phase_w}, 12'h001);
    blink = 1; pixel = 1; cmode = 2'b00;
    step(); chk("blink_hidden_rgb", rgb_w, 12'h000);
    blink = 0; pixel = 0; cursor = 1; cmode = 2'b10;
    step(); chk("blink_cursor_rgb", rgb_w, 12'h000);
    cursor = 0; cmode = 2'b00;
    vs_pulse(); chk("pulse3_phase", {11'd0, phase_w}, 12'h001);
    vs_pulse(); chk("pulse4_phase", {11'd0, phase_w}, 12'h000);

    // en_i low: inputs wander, every output must hold
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hsync = $urandom_range(0, 1); vsync = $urandom_range(0, 1);
      video_on = $urandom_range(0, 1); pixel = $urandom_range(0, 1);
      cursor = $urandom_range(0, 1); blink = $urandom_range(0, 1);
      cmode = 2'($urandom_range(0, 3)); fg = 12'($urandom); bg = 12'($urandom);
      step();
    end
    en = 1'b1;
    hsync = 0; vsync = 0; video_on = 1; pixel = 1; cursor = 0; blink = 0;
    cmode = 2'b00; fg = 12'h3C5; bg = 12'h000;
    repeat (3) step();

    // Asynchronous reset mid-frame, then full latency again
    hsync = 1; vsync = 1;
    repeat (4) step();
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    model_reset();
    #1;
    rst = 1'b0;
    step(); chk("post_rst_t0", {11'd0, hsync_w}, 12'h001);
    step(); chk("post_rst_t1", {11'd0, hsync_w}, 12'h001);
    step(); chk("post_rst_t2", {11'd0, hsync_w}, 12'h000);

    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) vsync = ~vsync;
      if ($urandom_range(0, 3) == 0) hsync = ~hsync;
      if ($urandom_range(0, 3) == 0) video_on = ~video_on;
      pixel = $urandom_range(0, 1); cursor = $urandom_range(0, 1);
      blink = $urandom_range(0, 1); cmode = 2'($urandom_range(0, 3));
      fg = 12'($urandom); bg = 12'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
